// File: rtl/clock_gen_pkg.sv
// clock_gen shared types: FSM state encoding and mode constants.
// No ports; imported by the interface, the step synchronizer and the top.
package clock_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        HALT = 2'd3
    } clk_state_t;

    localparam logic MODE_RUN  = 1'b0;
    localparam logic MODE_STEP = 1'b1;

endpackage

// File: rtl/clock_gen_if.sv
// clock_gen control/status bundle.
// master drives en, mode, step, hlt, delay; slave (the generator)
// drives cpu_clk, not_cpu_clk, rise_tick, fall_tick, halted, step_busy
// and, with CLOCK_GEN_CYCLE_COUNT_EN, cycle_count.
interface clock_gen_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic             mode;
    logic             step;
    logic             hlt;
    logic [DIV_W-1:0] delay;
    logic             cpu_clk;
    logic             not_cpu_clk;
    logic             rise_tick;
    logic             fall_tick;
    logic             halted;
    logic             step_busy;
`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output en, mode, step, hlt, delay,
        input  cpu_clk, not_cpu_clk, rise_tick, fall_tick,
        input  halted, step_busy, cycle_count
    );

    modport slave (
        input  en, mode, step, hlt, delay,
        output cpu_clk, not_cpu_clk, rise_tick, fall_tick,
        output halted, step_busy, cycle_count
    );
`else
    modport master (
        output en, mode, step, hlt, delay,
        input  cpu_clk, not_cpu_clk, rise_tick, fall_tick,
        input  halted, step_busy
    );

    modport slave (
        input  en, mode, step, hlt, delay,
        output cpu_clk, not_cpu_clk, rise_tick, fall_tick,
        output halted, step_busy
    );
`endif

endinterface

// File: rtl/clock_gen_step_sync.sv
// Step button synchronizer: 3-flop chain plus rising-edge detect.
// Ports: clk, rst (async, active high), async_in (raw level), edge_out.
module step_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic edge_out
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_out = s2 & ~s3;

endmodule

// File: rtl/clock_gen.sv
// Programmable CPU clock generator: divides clk by (delay+1) per phase,
// with RUN/STEP modes, sticky halt, global freeze (en) and edge ticks.
// Ports: clk, rst (async, active high), bus (clock_gen_if.slave).
// Optional cycle_count output enabled by macro CLOCK_GEN_CYCLE_COUNT_EN.
module clock_gen
    import clock_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    clock_gen_if.slave bus
);

    clk_state_t       state;
    logic [DIV_W-1:0] counter;
    logic [DIV_W-1:0] delay_q;
    logic             cpu_clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             halted_q;
    logic             busy_q;
    logic             step_edge;
    logic             expire;

    step_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.step),
        .edge_out (step_edge)
    );

    assign expire = (counter == delay_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOW;
            counter   <= '0;
            delay_q   <= bus.delay;
            cpu_clk_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            halted_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else if (!bus.en) begin
            // frozen: everything holds, only the ticks drop
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state)
                LOW: begin
                    if (expire) begin
                        counter <= '0;
                        if (bus.hlt) begin
                            state    <= HALT;
                            halted_q <= 1'b1;
                        end else if (bus.mode == MODE_RUN) begin
                            state     <= HIGH;
                            cpu_clk_q <= 1'b1;
                            rise_q    <= 1'b1;
                            delay_q   <= bus.delay;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                IDLE: begin
                    counter <= '0;
                    if (bus.hlt) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (bus.mode == MODE_RUN || step_edge) begin
                        state     <= HIGH;
                        cpu_clk_q <= 1'b1;
                        rise_q    <= 1'b1;
                        delay_q   <= bus.delay;
                        busy_q    <= (bus.mode == MODE_STEP);
                    end
                end
                HIGH: begin
                    // hlt and mode are not looked at here
                    if (expire) begin
                        state     <= LOW;
                        counter   <= '0;
                        cpu_clk_q <= 1'b0;
                        fall_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        delay_q   <= bus.delay;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                HALT: begin
                end
            endcase
        end
    end

    assign bus.cpu_clk     = cpu_clk_q;
    assign bus.not_cpu_clk = ~cpu_clk_q;
    assign bus.rise_tick   = rise_q;
    assign bus.fall_tick   = fall_q;
    assign bus.halted      = halted_q;
    assign bus.step_busy   = busy_q;

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // counts the cycle after each rise tick, so the value seen
    // alongside rise N is N-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rise_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.cycle_count = cnt_q;
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Scoreboard bench for clock_gen: expected ticks are queued by the
// stimulus process and popped by a negedge monitor.
module tb_clock_gen;
    import clock_pkg::*;

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 16;
`endif

    typedef struct {
        logic rise;
        int   at;
        logic busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   base = 0;
    exp_t exp_q[$];
    exp_t e;

    clock_gen_if #(.DIV_W(8), .CNT_W(TB_CNT_W)) bus ();

    clock_gen #(.DIV_W(8), .CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rise_tick || bus.fall_tick) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tick cyc=%0d rise=%0b fall=%0b",
                         cyc, bus.rise_tick, bus.fall_tick);
            end else begin
                e = exp_q.pop_front();
                if (e.rise !== bus.rise_tick || e.rise === bus.fall_tick ||
                    e.at != cyc || e.busy !== bus.step_busy ||
                    bus.cpu_clk !== e.rise) begin
                    failures++;
                    $display("FAIL tick got rise=%0b cyc=%0d busy=%0b clk=%0b exp rise=%0b cyc=%0d busy=%0b",
                             bus.rise_tick, cyc, bus.step_busy, bus.cpu_clk,
                             e.rise, e.at, e.busy);
                end
            end
        end
    end

    task automatic push(input logic r, input int at, input logic b);
        exp_t x;
        x.rise = r;
        x.at   = at;
        x.busy = b;
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
        #1;
    endtask

    task automatic start(input logic m, input logic [7:0] d);
        bus.mode  = m;
        bus.delay = d;
        bus.en    = 1'b1;
        bus.hlt   = 1'b0;
        bus.step  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en    = 1'b1;
        bus.mode  = MODE_RUN;
        bus.step  = 1'b0;
        bus.hlt   = 1'b0;
        bus.delay = 8'd0;
        @(negedge clk);
        #1;
        check("rst_cpu_clk", bus.cpu_clk, 1'b0);
        check("rst_not_cpu_clk", bus.not_cpu_clk, 1'b1);
        check("rst_rise", bus.rise_tick, 1'b0);
        check("rst_fall", bus.fall_tick, 1'b0);
        check("rst_halted", bus.halted, 1'b0);
        check("rst_busy", bus.step_busy, 1'b0);

        // RUN, delay 0: period 2, first rise on first edge
        start(MODE_RUN, 8'd0);
        for (int j = 0; j < 3; j++) begin
            push(1'b1, base + 1 + 2 * j, 1'b0);
            push(1'b0, base + 2 + 2 * j, 1'b0);
        end
        wait_cyc(base + 1);
        check("d0_not_cpu_clk", bus.not_cpu_clk, 1'b0);
        wait_cyc(base + 6);

        // RUN, delay 3 then 1 mid-high
        start(MODE_RUN, 8'd3);
        push(1'b1, base + 4, 1'b0);
        push(1'b0, base + 8, 1'b0);
        push(1'b1, base + 12, 1'b0);
        push(1'b0, base + 16, 1'b0);
        push(1'b1, base + 18, 1'b0);
        push(1'b0, base + 20, 1'b0);
        push(1'b1, base + 22, 1'b0);
        push(1'b0, base + 24, 1'b0);
        wait_cyc(base + 13);
        bus.delay = 8'd1;
        wait_cyc(base + 24);

        // STEP, delay 2; second pulse during HIGH is dropped
        start(MODE_STEP, 8'd2);
        push(1'b1, base + 8, 1'b1);
        push(1'b0, base + 11, 1'b0);
        wait_cyc(base + 5);
        bus.step = 1'b1;
        wait_cyc(base + 7);
        bus.step = 1'b0;
        wait_cyc(base + 9);
        check("step_busy_high", bus.step_busy, 1'b1);
        check("step_clk_high", bus.cpu_clk, 1'b1);
        bus.step = 1'b1;
        wait_cyc(base + 10);
        bus.step = 1'b0;
        wait_cyc(base + 12);
        check("step_busy_low", bus.step_busy, 1'b0);
        check("step_clk_low", bus.cpu_clk, 1'b0);
        wait_cyc(base + 25);
        check("step_idle_clk", bus.cpu_clk, 1'b0);

        // RUN, delay 1, halt requested during HIGH
        start(MODE_RUN, 8'd1);
        push(1'b1, base + 2, 1'b0);
        push(1'b0, base + 4, 1'b0);
        push(1'b1, base + 6, 1'b0);
        push(1'b0, base + 8, 1'b0);
        wait_cyc(base + 7);
        bus.hlt = 1'b1;
        wait_cyc(base + 9);
        check("halt_not_yet", bus.halted, 1'b0);
        wait_cyc(base + 10);
        check("halt_set", bus.halted, 1'b1);
        wait_cyc(base + 12);
        bus.mode = MODE_STEP;
        bus.step = 1'b1;
        wait_cyc(base + 14);
        bus.step = 1'b0;
        wait_cyc(base + 16);
        bus.mode = MODE_RUN;
        bus.hlt  = 1'b0;
        wait_cyc(base + 20);
        bus.step = 1'b1;
        wait_cyc(base + 23);
        bus.step = 1'b0;
        wait_cyc(base + 32);
        check("halt_sticky", bus.halted, 1'b1);
        check("halt_clk", bus.cpu_clk, 1'b0);
        rst = 1'b1;
        #1;
        check("halt_rst_async", bus.halted, 1'b0);
        @(negedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        push(1'b1, base + 2, 1'b0);
        push(1'b0, base + 4, 1'b0);
        wait_cyc(base + 4);

        // STEP, delay 0: step edge while frozen in IDLE is dropped
        start(MODE_STEP, 8'd0);
        wait_cyc(base + 3);
        bus.en   = 1'b0;
        bus.step = 1'b1;
        wait_cyc(base + 5);
        bus.step = 1'b0;
        wait_cyc(base + 8);
        bus.en = 1'b1;
        wait_cyc(base + 12);
        check("frozen_step_dropped", bus.cpu_clk, 1'b0);
        push(1'b1, base + 15, 1'b1);
        push(1'b0, base + 16, 1'b0);
        bus.step = 1'b1;
        wait_cyc(base + 14);
        bus.step = 1'b0;
        wait_cyc(base + 18);

        // RUN, delay 3: 5-cycle freeze mid-low, then reset mid-high
        start(MODE_RUN, 8'd3);
        push(1'b1, base + 4, 1'b0);
        push(1'b0, base + 8, 1'b0);
        push(1'b1, base + 17, 1'b0);
        wait_cyc(base + 9);
        bus.en = 1'b0;
        wait_cyc(base + 12);
        check("freeze_clk", bus.cpu_clk, 1'b0);
        wait_cyc(base + 14);
        bus.en = 1'b1;
        wait_cyc(base + 19);
        check("pre_rst_high", bus.cpu_clk, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_clk", bus.cpu_clk, 1'b0);
        check("async_rst_not", bus.not_cpu_clk, 1'b1);
        @(negedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        push(1'b1, base + 4, 1'b0);
        push(1'b0, base + 8, 1'b0);
        wait_cyc(base + 8);

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
        start(MODE_RUN, 8'd0);
        for (int j = 0; j < 17; j++) begin
            push(1'b1, base + 1 + 2 * j, 1'b0);
            push(1'b0, base + 2 + 2 * j, 1'b0);
        end
        for (int j = 0; j < 17; j++) begin
            wait_cyc(base + 1 + 2 * j);
            check("cycle_count", 32'(bus.cycle_count), 32'(j % 16));
        end
        wait_cyc(base + 34);
`endif

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
